// File: rtl/perceptron_trainer.sv
// Perceptron training engine: valid/ready sample stream, serial MAC, parallel saturating update.
// A sample occupies NUM_IN+2 cycles (accept, NUM_IN MAC, update); in_ready is high only while waiting.
module perceptron_trainer #(
   parameter int NUM_IN = 2,
   parameter int X_W = 8,
   parameter int W_W = 16,
   parameter int FRAC = 8,
   parameter logic [W_W-1:0] LR = 16'h0100,
   parameter int MAX_EPOCH = 16,
   parameter int EPOCH_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_IN*X_W-1:0]    in_x,
   input  logic                     in_t,
   input  logic                     in_last,
   output logic [NUM_IN*W_W-1:0]    weights,
   output logic [W_W-1:0]           bias,
   output logic                     busy,
   output logic                     done,
   output logic                     converged,
   output logic [EPOCH_W-1:0]       epoch_count,
   output logic [EPOCH_W-1:0]       err_count
);

   localparam int ACC_W = X_W + W_W + $clog2(NUM_IN + 1);
   localparam int PROD_W = X_W + W_W;
   localparam int SUM_W = PROD_W + 1;
   localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
   localparam logic signed [W_W-1:0] LR_S = LR;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WAIT      = 3'd1;
   localparam logic [2:0] S_MAC       = 3'd2;
   localparam logic [2:0] S_UPDATE    = 3'd3;
   localparam logic [2:0] S_EPOCH_END = 3'd4;
   localparam logic [2:0] S_DONE      = 3'd5;

   // FRAC only fixes the scaling shared by weights, bias and LR; it must leave room for a sign bit
   if (NUM_IN < 1 || MAX_EPOCH < 1 || FRAC >= W_W) begin : gBadParams
      $error("perceptron_trainer: illegal parameter set");
   end

   logic [2:0]               state;
   logic signed [W_W-1:0]    wReg [NUM_IN];
   logic signed [W_W-1:0]    biasReg;
   logic signed [X_W-1:0]    xReg [NUM_IN];
   logic                     tReg;
   logic                     lastReg;
   logic signed [ACC_W-1:0]  acc;
   logic [IDX_W-1:0]         idx;
   logic [EPOCH_W-1:0]       epochCnt;
   logic [EPOCH_W-1:0]       errCnt;
   logic                     convReg;

   logic signed [PROD_W-1:0] macProd;
   logic [W_W-1:0]           wNext [NUM_IN];
   logic signed [SUM_W-1:0]  biasSum;
   logic [W_W-1:0]           biasNext;
   logic                     mismatch;
   logic [EPOCH_W-1:0]       epochNext;

   function automatic logic [W_W-1:0] sat(input logic [SUM_W-1:0] v);
      logic [W_W-1:0] r;
      if (v[SUM_W-1:W_W-1] == {(SUM_W-W_W+1){v[SUM_W-1]}})
         r = v[W_W-1:0];
      else if (v[SUM_W-1])
         r = {1'b1, {(W_W-1){1'b0}}};
      else
         r = {1'b0, {(W_W-1){1'b1}}};
      return r;
   endfunction

   assign macProd = PROD_W'(xReg[idx]) * PROD_W'(wReg[idx]);

   // Target +1 adds LR*x, target -1 subtracts it; sums are formed wide and then clamped
   for (genvar g = 0; g < NUM_IN; g++) begin : gLane
      logic signed [PROD_W-1:0] step;
      logic signed [SUM_W-1:0]  sum;
      assign step = PROD_W'(xReg[g]) * PROD_W'(LR_S);
      assign sum = tReg ? SUM_W'(wReg[g]) + SUM_W'(step) : SUM_W'(wReg[g]) - SUM_W'(step);
      assign wNext[g] = sat(sum);
      assign weights[g*W_W +: W_W] = wReg[g];
   end

   assign biasSum = tReg ? SUM_W'(biasReg) + SUM_W'(LR_S) : SUM_W'(biasReg) - SUM_W'(LR_S);
   assign biasNext = sat(biasSum);
   assign mismatch = (~acc[ACC_W-1]) != tReg;
   assign epochNext = epochCnt + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         for (int i = 0; i < NUM_IN; i++) begin
            wReg[i] <= '0;
            xReg[i] <= '0;
         end
         biasReg <= '0;
         tReg <= 1'b0;
         lastReg <= 1'b0;
         acc <= '0;
         idx <= '0;
         epochCnt <= '0;
         errCnt <= '0;
         convReg <= 1'b0;
      end else if (abort) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  for (int i = 0; i < NUM_IN; i++) wReg[i] <= '0;
                  biasReg <= '0;
                  epochCnt <= '0;
                  errCnt <= '0;
                  convReg <= 1'b0;
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (in_valid) begin
                  for (int i = 0; i < NUM_IN; i++) xReg[i] <= $signed(in_x[i*X_W +: X_W]);
                  tReg <= in_t;
                  lastReg <= in_last;
                  acc <= ACC_W'(biasReg);
                  idx <= '0;
                  state <= S_MAC;
               end
            end
            S_MAC: begin
               acc <= acc + ACC_W'(macProd);
               if (idx == IDX_W'(NUM_IN - 1)) state <= S_UPDATE;
               else idx <= idx + 1'b1;
            end
            S_UPDATE: begin
               if (mismatch) begin
                  if (errCnt != '1) errCnt <= errCnt + 1'b1;
                  for (int i = 0; i < NUM_IN; i++) wReg[i] <= wNext[i];
                  biasReg <= biasNext;
               end
               state <= lastReg ? S_EPOCH_END : S_WAIT;
            end
            S_EPOCH_END: begin
               epochCnt <= epochNext;
               if (errCnt == '0) begin
                  convReg <= 1'b1;
                  state <= S_DONE;
               end else if (epochNext == EPOCH_W'(MAX_EPOCH)) begin
                  state <= S_DONE;
               end else begin
                  errCnt <= '0;
                  state <= S_WAIT;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign in_ready = (state == S_WAIT);
   assign busy = (state != S_IDLE) && (state != S_DONE);
   assign done = (state == S_DONE);
   assign converged = convReg;
   assign bias = biasReg;
   assign epoch_count = epochCnt;
   assign err_count = errCnt;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer: default, MAX_EPOCH=4 and LR=0x7F00 instances share one stimulus stream.
module tb_perceptron_trainer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic in_valid = 1'b0;
   logic [15:0] in_x = '0;
   logic in_t = 1'b0;
   logic in_last = 1'b0;

   logic aReady, aBusy, aDone, aConv;
   logic [31:0] aW;
   logic [15:0] aBias;
   logic [7:0] aEpoch, aErr;
   logic xReady, xBusy, xDone, xConv;
   logic [31:0] xW;
   logic [15:0] xBias;
   logic [7:0] xEpoch, xErr;
   logic lReady, lBusy, lDone, lConv;
   logic [31:0] lW;
   logic [15:0] lBias;
   logic [7:0] lEpoch, lErr;

   int nChecks = 0;
   int nPass = 0;

   always #5 clk = ~clk;

   perceptron_trainer dutA (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .in_valid(in_valid), .in_ready(aReady), .in_x(in_x), .in_t(in_t), .in_last(in_last),
      .weights(aW), .bias(aBias), .busy(aBusy), .done(aDone), .converged(aConv),
      .epoch_count(aEpoch), .err_count(aErr));

   perceptron_trainer #(.MAX_EPOCH(4)) dutX (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .in_valid(in_valid), .in_ready(xReady), .in_x(in_x), .in_t(in_t), .in_last(in_last),
      .weights(xW), .bias(xBias), .busy(xBusy), .done(xDone), .converged(xConv),
      .epoch_count(xEpoch), .err_count(xErr));

   perceptron_trainer #(.LR(16'h7F00)) dutL (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .in_valid(in_valid), .in_ready(lReady), .in_x(in_x), .in_t(in_t), .in_last(in_last),
      .weights(lW), .bias(lBias), .busy(lBusy), .done(lDone), .converged(lConv),
      .epoch_count(lEpoch), .err_count(lErr));

   typedef struct {
      bit          rstFirst;
      logic [7:0]  x0, x1;
      bit          t, last;
      logic [7:0]  eErr, eEpoch;
      logic [15:0] eW0, eW1, eBias;
      bit          eDone;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic doStart();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic checkZero(input string tag);
      check({tag, ".busy"}, aBusy, 0);
      check({tag, ".done"}, aDone, 0);
      check({tag, ".conv"}, aConv, 0);
      check({tag, ".ready"}, aReady, 0);
      check({tag, ".weights"}, aW, 0);
      check({tag, ".bias"}, aBias, 0);
      check({tag, ".epoch"}, aEpoch, 0);
      check({tag, ".err"}, aErr, 0);
   endtask

   // Waits for in_ready of the default instance, then presents one sample for exactly one edge
   task automatic sendSample(input logic [7:0] x0, input logic [7:0] x1, input logic t, input logic last);
      int n = 0;
      while (!aReady && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!aReady) begin
         nChecks++;
         $display("FAIL readyTimeout: in_ready=%0b, expected 1", aReady);
      end else begin
         in_x = {x1, x0}; in_t = t; in_last = last; in_valid = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic settle();
      int n = 0;
      while (!(aReady || aDone) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!(aReady || aDone)) begin
         nChecks++;
         $display("FAIL settleTimeout: in_ready=%0b done=%0b, expected either high", aReady, aDone);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int acceptAt[8];
      int nAcc;
      logic [7:0] xorTab[4][3];

      //            rst  x0     x1     t  last  err   epoch  w0        w1        bias      done
      vecs[0]  = '{1, 8'h01, 8'h01, 1, 0, 8'd0, 8'd0, 16'h0000, 16'h0000, 16'h0000, 0};
      vecs[1]  = '{0, 8'h01, 8'hFF, 0, 0, 8'd1, 8'd0, 16'hFF00, 16'h0100, 16'hFF00, 0};
      vecs[2]  = '{1, 8'h01, 8'h01, 1, 0, 8'd0, 8'd0, 16'h0000, 16'h0000, 16'h0000, 0};
      vecs[3]  = '{0, 8'h01, 8'hFF, 0, 0, 8'd1, 8'd0, 16'hFF00, 16'h0100, 16'hFF00, 0};
      vecs[4]  = '{0, 8'hFF, 8'h01, 0, 0, 8'd2, 8'd0, 16'h0000, 16'h0000, 16'hFE00, 0};
      vecs[5]  = '{0, 8'hFF, 8'hFF, 0, 1, 8'd0, 8'd1, 16'h0000, 16'h0000, 16'hFE00, 0};
      vecs[6]  = '{0, 8'h01, 8'h01, 1, 0, 8'd1, 8'd1, 16'h0100, 16'h0100, 16'hFF00, 0};
      vecs[7]  = '{0, 8'h01, 8'hFF, 0, 0, 8'd1, 8'd1, 16'h0100, 16'h0100, 16'hFF00, 0};
      vecs[8]  = '{0, 8'hFF, 8'h01, 0, 0, 8'd1, 8'd1, 16'h0100, 16'h0100, 16'hFF00, 0};
      vecs[9]  = '{0, 8'hFF, 8'hFF, 0, 1, 8'd0, 8'd2, 16'h0100, 16'h0100, 16'hFF00, 0};
      vecs[10] = '{0, 8'h01, 8'h01, 1, 0, 8'd0, 8'd2, 16'h0100, 16'h0100, 16'hFF00, 0};
      vecs[11] = '{0, 8'h01, 8'hFF, 0, 0, 8'd0, 8'd2, 16'h0100, 16'h0100, 16'hFF00, 0};
      vecs[12] = '{0, 8'hFF, 8'h01, 0, 0, 8'd0, 8'd2, 16'h0100, 16'h0100, 16'hFF00, 0};
      vecs[13] = '{0, 8'hFF, 8'hFF, 0, 1, 8'd0, 8'd3, 16'h0100, 16'h0100, 16'hFF00, 1};

      xorTab[0] = '{8'h01, 8'h01, 8'd0};
      xorTab[1] = '{8'h01, 8'hFF, 8'd1};
      xorTab[2] = '{8'hFF, 8'h01, 8'd1};
      xorTab[3] = '{8'hFF, 8'hFF, 8'd0};

      // first sample pair, then bipolar AND to convergence
      for (int i = 0; i < 14; i++) begin
         if (vecs[i].rstFirst) begin
            doReset();
            checkZero($sformatf("reset%0d", i));
            doStart();
            check($sformatf("startReady%0d", i), aReady, 1);
            check($sformatf("startBusy%0d", i), aBusy, 1);
         end
         sendSample(vecs[i].x0, vecs[i].x1, vecs[i].t, vecs[i].last);
         settle();
         check($sformatf("v%0d.err", i), aErr, vecs[i].eErr);
         check($sformatf("v%0d.epoch", i), aEpoch, vecs[i].eEpoch);
         check($sformatf("v%0d.w0", i), aW[15:0], vecs[i].eW0);
         check($sformatf("v%0d.w1", i), aW[31:16], vecs[i].eW1);
         check($sformatf("v%0d.bias", i), aBias, vecs[i].eBias);
         check($sformatf("v%0d.done", i), aDone, vecs[i].eDone);
      end
      check("and.converged", aConv, 1);
      check("and.busy", aBusy, 0);

      // bipolar XOR never converges; MAX_EPOCH=4 instance must give up after 4 epochs
      doReset();
      doStart();
      for (int e = 0; e < 4; e++)
         for (int s = 0; s < 4; s++)
            sendSample(xorTab[s][0], xorTab[s][1], xorTab[s][2][0], s == 3);
      for (int n = 0; n < 20 && !xDone; n++) @(negedge clk);
      check("xor.done", xDone, 1);
      check("xor.converged", xConv, 0);
      check("xor.epoch", xEpoch, 4);

      // large LR: w0 saturates positive, bias goes to -LR
      doReset();
      doStart();
      sendSample(8'h80, 8'h00, 1'b0, 1'b1);
      settle();
      check("lr.w0", lW[15:0], 16'h7FFF);
      check("lr.w1", lW[31:16], 16'h0000);
      check("lr.bias", lBias, 16'h8100);
      check("lr.epoch", lEpoch, 1);

      // in_valid held high: accepts every NUM_IN+2 = 4 cycles
      doReset();
      doStart();
      in_x = {8'h01, 8'h01}; in_t = 1'b1; in_last = 1'b0; in_valid = 1'b1;
      nAcc = 0;
      for (int c = 0; c < 16; c++) begin
         if (aReady && nAcc < 8) begin
            acceptAt[nAcc] = c;
            nAcc++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("lat.count", nAcc, 4);
      for (int k = 1; k < 4; k++)
         check($sformatf("lat.gap%0d", k), acceptAt[k] - acceptAt[k-1], 4);

      // in_valid pulse and start during MAC are both ignored
      sendSample(8'h01, 8'hFF, 1'b0, 1'b0);
      settle();
      sendSample(8'h01, 8'h01, 1'b1, 1'b0);
      start = 1'b1; in_valid = 1'b1; in_x = {8'h05, 8'h05}; in_t = 1'b0;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b0;
      settle();
      check("mac.err", aErr, 2);
      check("mac.w0", aW[15:0], 16'h0000);
      check("mac.w1", aW[31:16], 16'h0200);
      check("mac.bias", aBias, 16'h0000);

      // abort in MAC: idle next cycle, no update afterwards
      sendSample(8'hFF, 8'h01, 1'b0, 1'b0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort.busy", aBusy, 0);
      check("abort.ready", aReady, 0);
      check("abort.done", aDone, 0);
      repeat (4) @(negedge clk);
      check("abort.idle", aBusy, 0);
      check("abort.w0", aW[15:0], 16'h0000);
      check("abort.w1", aW[31:16], 16'h0200);
      check("abort.bias", aBias, 16'h0000);
      check("abort.err", aErr, 2);

      // restart from IDLE clears, then rst mid-sample zeroes everything
      doStart();
      check("restart.w1", aW[31:16], 16'h0000);
      check("restart.err", aErr, 0);
      sendSample(8'h01, 8'hFF, 1'b0, 1'b0);
      settle();
      sendSample(8'h01, 8'h01, 1'b1, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkZero("midRst");

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
